mem_master: RTL and testbench
=============================

MEM_MASTER -- requirements
Module: mem_master

Interface
REQ-001 Parameter: WAIT_CYCLES, default 1, read settle cycles per beat (legal 1..15).
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 req_valid  input  1  host request present.
REQ-005 req_ready  output  1  block accepts a request (high only in IDLE).
REQ-006 req_rw  input  1  1 = read burst, 0 = write burst (same polarity as RAM RW).
REQ-007 req_addr  input  11  start address; bit 10 selects bank (0 = RAM1, 1 = RAM2).
REQ-008 req_len  input  4  burst beats minus one (0 = 1 beat, 15 = 16 beats).
REQ-009 wr_valid  input  1  write data beat present.
REQ-010 wr_ready  output  1  block accepts write data beat.
REQ-011 wr_data  input  8  write data beat.
REQ-012 rsp_valid  output  1  response present.
REQ-013 rsp_ready  input  1  host accepts response.
REQ-014 rsp_data  output  8  read byte; 0 for write completion.
REQ-015 rsp_last  output  1  final response of burst.
REQ-016 mem_addr  output  11  to decoder in_line (bit 10) and RAM addr (bits 9:0).
REQ-017 mem_en  output  1  to decoder memory_en.
REQ-018 mem_rw  output  1  to RAM RW; 1 = read, 0 = write.
REQ-019 mem_wdata  output  8  to RAM idata.
REQ-020 mem_rdata  input  8  OR of both RAM odata outputs.

Function
REQ-021 States SHALL be IDLE, RADDR, RHOLD, WSETUP, WSTROBE, WRECOV, WRESP.
REQ-022 IDLE: req_ready=1, mem_en=0, mem_rw=1; req_valid&&req_ready at an edge latches addr/len/rw and enters RADDR (rw=1) or WSETUP (rw=0).
REQ-023 RADDR: mem_en=1, mem_rw=1, mem_addr=current address, held exactly WAIT_CYCLES cycles; on the last edge mem_rdata registers into rsp_data, rsp_valid=1, rsp_last=(beat==len), state RHOLD.
REQ-024 Read latency: request accepted at edge N, rsp_valid high after edge N+WAIT_CYCLES.
REQ-025 RHOLD: rsp_valid, rsp_data, rsp_last, mem_addr held until rsp_valid&&rsp_ready; then address+1 and RADDR, or IDLE if last beat.
REQ-026 WSETUP: mem_en=1, mem_rw=1, wr_ready=1; wr_valid&&wr_ready latches wr_data into mem_wdata, state WSTROBE.
REQ-027 WSTROBE: mem_rw=0 for exactly one cycle; mem_addr and mem_wdata SHALL not change while mem_rw=0.
REQ-028 WRECOV: mem_rw=1 one cycle, addr/data unchanged; then address+1 and WSETUP, or WRESP if last beat.
REQ-029 WRESP: rsp_valid=1, rsp_last=1, rsp_data=0 until rsp_ready; then IDLE.
REQ-030 wr_ready SHALL be 0 outside WSETUP; rsp_valid SHALL be 0 outside RHOLD/WRESP.
REQ-031 Address increments modulo 2048: 2047 wraps to 0; 1023 to 1024 crosses bank with no extra cycles.
REQ-032 Beat counter 4-bit; burst ends after req_len+1 beats exactly.
REQ-033 rsp_ready high in the cycle rsp_valid rises completes the handshake at that edge.
REQ-034 req_valid outside IDLE SHALL be ignored; request inputs sampled only at acceptance.
REQ-035 wr_valid stalled indefinitely SHALL keep WSETUP with mem_rw=1.

Reset
REQ-036 rst high at an edge SHALL force IDLE, req_ready=1 after that edge, mem_en=0, mem_rw=1, mem_addr=0, mem_wdata=0, wr_ready=0, rsp_valid=0, rsp_data=0, rsp_last=0, beat counter=0.
REQ-037 rst during any state, including WSTROBE, SHALL end the cycle with mem_rw=1; remaining beats and pending responses are discarded.

Verification
REQ-038 Read addr 1, len 0, WAIT_CYCLES 1, memory1[1]=0x3C -> rsp_valid after 1 cycle, rsp_data=0x3C, rsp_last=1, mem_en=1 only during RADDR/RHOLD.
REQ-039 Write addr 1034, len 2, data 0xAC,0x11,0x22 -> three single-cycle mem_rw=0 pulses at 1034,1035,1036 with stable addr/data; one WRESP; read-back returns same bytes.
REQ-040 Read addr 1022, len 3 -> mem_addr 1022,1023,1024,1025; bank switches at 1024; four responses, rsp_last on fourth only.
REQ-041 Read addr 2047, len 1 -> mem_addr 2047 then 0.
REQ-042 Read with rsp_ready low 5 cycles -> rsp_valid/rsp_data stable, no address advance; rsp_ready pulse advances one beat.
REQ-043 rst asserted during WSTROBE of beat 2 -> mem_rw=1 and IDLE after the edge, no further writes, req_ready=1.

Source files
------------

// File: rtl/mem_master.sv
// rtl/mem_master.sv - burst master sequencing host read/write bursts onto a two-bank byte RAM
module mem_master #(
   parameter int WAIT_CYCLES = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_rw,
   input  logic [10:0] req_addr,
   input  logic [3:0]  req_len,
   input  logic        wr_valid,
   output logic        wr_ready,
   input  logic [7:0]  wr_data,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [7:0]  rsp_data,
   output logic        rsp_last,
   output logic [10:0] mem_addr,
   output logic        mem_en,
   output logic        mem_rw,
   output logic [7:0]  mem_wdata,
   input  logic [7:0]  mem_rdata
);

   typedef enum logic [2:0] {
      IDLE, RADDR, RHOLD, WSETUP, WSTROBE, WRECOV, WRESP
   } state_t;

   // Settle counter value on the final read-address cycle of a beat.
   localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES - 1);

   state_t      state, state_nxt;
   logic [10:0] addr;
   logic [3:0]  len;
   logic [3:0]  beat;
   logic [3:0]  wait_cnt;
   logic        last_beat;

   assign last_beat = (beat == len);
   assign mem_addr  = addr;

   // State register; reset lands in IDLE so mem_rw returns high even mid-strobe.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state and handshake/strobe outputs, all decoded from the current state.
   always_comb begin
      state_nxt = state;
      req_ready = 1'b0;
      wr_ready  = 1'b0;
      rsp_valid = 1'b0;
      mem_en    = 1'b1;
      mem_rw    = 1'b1;
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            mem_en    = 1'b0;
            if (req_valid) state_nxt = req_rw ? RADDR : WSETUP;
         end
         RADDR: begin
            if (wait_cnt == WAIT_LAST) state_nxt = RHOLD;
         end
         RHOLD: begin
            rsp_valid = 1'b1;
            if (rsp_ready) state_nxt = last_beat ? IDLE : RADDR;
         end
         WSETUP: begin
            wr_ready = 1'b1;
            if (wr_valid) state_nxt = WSTROBE;
         end
         WSTROBE: begin
            mem_rw    = 1'b0;
            state_nxt = WRECOV;
         end
         WRECOV: begin
            state_nxt = last_beat ? WRESP : WSETUP;
         end
         WRESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) state_nxt = IDLE;
         end
         default: begin
            mem_en    = 1'b0;
            state_nxt = IDLE;
         end
      endcase
   end

   // Burst datapath: request capture, settle count, read capture, address/beat advance.
   always_ff @(posedge clk) begin
      if (rst) begin
         addr      <= 11'd0;
         len       <= 4'd0;
         beat      <= 4'd0;
         wait_cnt  <= 4'd0;
         rsp_data  <= 8'd0;
         rsp_last  <= 1'b0;
         mem_wdata <= 8'd0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  addr     <= req_addr;
                  len      <= req_len;
                  beat     <= 4'd0;
                  wait_cnt <= 4'd0;
               end
            end
            RADDR: begin
               if (wait_cnt == WAIT_LAST) begin
                  wait_cnt <= 4'd0;
                  rsp_data <= mem_rdata;
                  rsp_last <= last_beat;
               end else begin
                  wait_cnt <= wait_cnt + 4'd1;
               end
            end
            RHOLD: begin
               // The address only moves once the byte has been taken, so the
               // RAM keeps presenting the same location during a stall.
               if (rsp_ready && !last_beat) begin
                  addr <= addr + 11'd1;
                  beat <= beat + 4'd1;
               end
            end
            WSETUP: begin
               if (wr_valid) mem_wdata <= wr_data;
            end
            WRECOV: begin
               if (last_beat) begin
                  rsp_data <= 8'd0;
                  rsp_last <= 1'b1;
               end else begin
                  addr <= addr + 11'd1;
                  beat <= beat + 4'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_master.sv
// tb/tb_mem_master.sv - self-checking bench for mem_master against a two-bank RAM and byte-array model
`timescale 1ns/1ps
module tb_mem_master;

   localparam int WC = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready, req_rw;
   logic [10:0] req_addr;
   logic [3:0]  req_len;
   logic        wr_valid, wr_ready;
   logic [7:0]  wr_data;
   logic        rsp_valid, rsp_ready, rsp_last;
   logic [7:0]  rsp_data;
   logic [10:0] mem_addr;
   logic        mem_en, mem_rw;
   logic [7:0]  mem_wdata, mem_rdata;

   always #5 clk = ~clk;

   mem_master #(.WAIT_CYCLES(WC)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
      .req_addr(req_addr), .req_len(req_len),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_last(rsp_last),
      .mem_addr(mem_addr), .mem_en(mem_en), .mem_rw(mem_rw),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   // Environment: two 1 KiB RAMs selected by address bit 10, outputs ORed.
   logic [7:0] ram1 [1024];
   logic [7:0] ram2 [1024];
   // Reference model: flat 2 KiB byte array updated by the bench's own view of each burst.
   logic [7:0] ref_mem [2048];

   int checks = 0, errors = 0;
   int wr_pulses = 0, exp_pulses = 0;

   assign mem_rdata = ((mem_en && mem_rw && !mem_addr[10]) ? ram1[mem_addr[9:0]] : 8'h00) |
                      ((mem_en && mem_rw &&  mem_addr[10]) ? ram2[mem_addr[9:0]] : 8'h00);

   always @(posedge clk) begin
      if (mem_en && !mem_rw) begin
         if (mem_addr[10]) ram2[mem_addr[9:0]] <= mem_wdata;
         else              ram1[mem_addr[9:0]] <= mem_wdata;
         wr_pulses = wr_pulses + 1;
      end
   end

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Request inputs are noise while a burst runs; only the acceptance edge may sample them.
   task automatic noise();
      req_valid = 1'($urandom_range(0, 1));
      req_rw    = 1'($urandom_range(0, 1));
      req_addr  = 11'($urandom);
      req_len   = 4'($urandom);
   endtask

   task automatic quiet();
      req_valid = 1'b0;
   endtask

   task automatic check_reset_values();
      check("rst_req_ready", req_ready, 1);
      check("rst_mem_en", mem_en, 0);
      check("rst_mem_rw", mem_rw, 1);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_mem_wdata", mem_wdata, 0);
      check("rst_wr_ready", wr_ready, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_data", rsp_data, 0);
      check("rst_rsp_last", rsp_last, 0);
   endtask

   task automatic run_read(input logic [10:0] a, input logic [3:0] l, input int stall,
                           output logic [10:0] end_addr, output int beats);
      logic [10:0] cur;
      cur      = a;
      beats    = 0;
      end_addr = a;
      check("rd_idle_ready", req_ready, 1);
      req_valid = 1'b1; req_rw = 1'b1; req_addr = a; req_len = l;
      @(negedge clk); noise();
      for (int b = 0; b <= int'(l); b++) begin
         for (int k = 0; k < WC; k++) begin
            check("rd_addr_en", mem_en, 1);
            check("rd_addr_rw", mem_rw, 1);
            check("rd_addr", mem_addr, cur);
            check("rd_addr_no_rsp", rsp_valid, 0);
            @(negedge clk); noise();
         end
         check("rd_rsp_valid", rsp_valid, 1);
         check("rd_rsp_data", rsp_data, ref_mem[cur]);
         check("rd_rsp_last", rsp_last, (b == int'(l)));
         check("rd_hold_en", mem_en, 1);
         for (int s = 0; s < stall; s++) begin
            rsp_ready = 1'b0;
            @(negedge clk); noise();
            check("rd_stall_valid", rsp_valid, 1);
            check("rd_stall_data", rsp_data, ref_mem[cur]);
            check("rd_stall_addr", mem_addr, cur);
         end
         rsp_ready = 1'b1;
         if (b == int'(l)) quiet();
         end_addr = cur;
         beats++;
         @(negedge clk);
         rsp_ready = 1'b0;
         if (b != int'(l)) noise();
         cur = cur + 11'd1;
      end
      check("rd_done_ready", req_ready, 1);
      check("rd_done_en", mem_en, 0);
      check("rd_done_valid", rsp_valid, 0);
   endtask

   task automatic run_write(input logic [10:0] a, input logic [3:0] l, input logic [7:0] d [16],
                            input int wstall, input int rstall, input int cut_beat,
                            output logic [10:0] end_addr, output int beats);
      logic [10:0] cur;
      cur      = a;
      beats    = 0;
      end_addr = a;
      check("wr_idle_ready", req_ready, 1);
      req_valid = 1'b1; req_rw = 1'b0; req_addr = a; req_len = l;
      @(negedge clk); noise();
      for (int b = 0; b <= int'(l); b++) begin
         for (int s = 0; s <= wstall; s++) begin
            check("wr_setup_ready", wr_ready, 1);
            check("wr_setup_rw", mem_rw, 1);
            check("wr_setup_en", mem_en, 1);
            check("wr_setup_no_rsp", rsp_valid, 0);
            if (s == wstall) begin wr_valid = 1'b1; wr_data = d[b]; end
            else             begin wr_valid = 1'b0; wr_data = 8'($urandom); end
            @(negedge clk); noise();
         end
         wr_valid = 1'b0; wr_data = 8'($urandom);
         check("wr_strobe_rw", mem_rw, 0);
         check("wr_strobe_addr", mem_addr, cur);
         check("wr_strobe_data", mem_wdata, d[b]);
         check("wr_strobe_ready", wr_ready, 0);
         ref_mem[cur] = d[b];
         exp_pulses++;
         beats++;
         end_addr = cur;
         if (b == cut_beat) begin
            rst = 1'b1;
            quiet();
            return;
         end
         @(negedge clk); noise();
         check("wr_recov_rw", mem_rw, 1);
         check("wr_recov_addr", mem_addr, cur);
         check("wr_recov_data", mem_wdata, d[b]);
         @(negedge clk); noise();
         cur = cur + 11'd1;
      end
      check("wr_resp_valid", rsp_valid, 1);
      check("wr_resp_last", rsp_last, 1);
      check("wr_resp_data", rsp_data, 0);
      check("wr_resp_wr_ready", wr_ready, 0);
      for (int s = 0; s < rstall; s++) begin
         @(negedge clk); noise();
         check("wr_resp_stall_valid", rsp_valid, 1);
      end
      rsp_ready = 1'b1;
      quiet();
      @(negedge clk);
      rsp_ready = 1'b0;
      check("wr_done_ready", req_ready, 1);
      check("wr_done_valid", rsp_valid, 0);
   endtask

   typedef struct {
      logic        rw;
      logic [10:0] addr;
      logic [3:0]  len;
      int          stall;
      logic [7:0]  wd0, wd1, wd2;
      logic [10:0] exp_end;
      int          exp_beats;
   } vec_t;

   vec_t        vt [9];
   logic [7:0]  wd [16];
   logic [10:0] ea, exp_end;
   int          nb;

   initial begin
      vt[0] = '{1'b1, 11'd1,    4'd0,  0, 8'h00, 8'h00, 8'h00, 11'd1,    1};
      vt[1] = '{1'b0, 11'd1034, 4'd2,  0, 8'hAC, 8'h11, 8'h22, 11'd1036, 3};
      vt[2] = '{1'b1, 11'd1034, 4'd2,  0, 8'h00, 8'h00, 8'h00, 11'd1036, 3};
      vt[3] = '{1'b1, 11'd1022, 4'd3,  0, 8'h00, 8'h00, 8'h00, 11'd1025, 4};
      vt[4] = '{1'b1, 11'd2047, 4'd1,  0, 8'h00, 8'h00, 8'h00, 11'd0,    2};
      vt[5] = '{1'b1, 11'd500,  4'd1,  5, 8'h00, 8'h00, 8'h00, 11'd501,  2};
      vt[6] = '{1'b0, 11'd2046, 4'd3,  2, 8'h5A, 8'hA5, 8'h0F, 11'd1,    4};
      vt[7] = '{1'b1, 11'd2046, 4'd3,  1, 8'h00, 8'h00, 8'h00, 11'd1,    4};
      vt[8] = '{1'b1, 11'd0,    4'd15, 0, 8'h00, 8'h00, 8'h00, 11'd15,   16};

      for (int i = 0; i < 1024; i++) begin
         ram1[i] = 8'($urandom);
         ram2[i] = 8'($urandom);
         ref_mem[i]        = ram1[i];
         ref_mem[i + 1024] = ram2[i];
      end
      ram1[1] = 8'h3C;
      ref_mem[1] = 8'h3C;

      rst = 1'b1; req_valid = 1'b0; req_rw = 1'b0; req_addr = 11'd0; req_len = 4'd0;
      wr_valid = 1'b0; wr_data = 8'd0; rsp_ready = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_values();
      rst = 1'b0;
      @(negedge clk);

      // Directed vectors
      for (int i = 0; i < 9; i++) begin
         if (vt[i].rw) begin
            run_read(vt[i].addr, vt[i].len, vt[i].stall, ea, nb);
         end else begin
            wd[0] = vt[i].wd0; wd[1] = vt[i].wd1; wd[2] = vt[i].wd2;
            for (int j = 3; j < 16; j++) wd[j] = 8'($urandom);
            run_write(vt[i].addr, vt[i].len, wd, vt[i].stall, 1, -1, ea, nb);
         end
         check("vec_end_addr", ea, vt[i].exp_end);
         check("vec_beats", nb, vt[i].exp_beats);
         check("vec_write_pulses", wr_pulses, exp_pulses);
      end

      // Reset during the write strobe of the second beat
      for (int j = 0; j < 16; j++) wd[j] = 8'($urandom);
      run_write(11'd100, 4'd3, wd, 0, 0, 1, ea, nb);
      @(negedge clk);
      check_reset_values();
      rst = 1'b0;
      repeat (4) @(negedge clk);
      check("cut_no_more_writes", wr_pulses, exp_pulses);
      check("cut_idle_ready", req_ready, 1);
      run_read(11'd100, 4'd3, 0, ea, nb);
      check("cut_readback_beats", nb, 4);

      // Randomised bursts against the byte-array model
      for (int i = 0; i < 40; i++) begin
         logic        rw;
         logic [10:0] a;
         logic [3:0]  l;
         rw = 1'($urandom_range(0, 1));
         a  = 11'($urandom_range(0, 2047));
         l  = 4'($urandom_range(0, 15));
         exp_end = 11'((int'(a) + int'(l)) % 2048);
         if (rw) begin
            run_read(a, l, $urandom_range(0, 3), ea, nb);
         end else begin
            for (int j = 0; j < 16; j++) wd[j] = 8'($urandom);
            run_write(a, l, wd, $urandom_range(0, 3), $urandom_range(0, 3), -1, ea, nb);
         end
         check("rand_end_addr", ea, exp_end);
         check("rand_beats", nb, int'(l) + 1);
         check("rand_write_pulses", wr_pulses, exp_pulses);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
